lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_pkg.sv | 24 ++
 rtl/water_level.sv | 43 ++++
 rtl/lock_controller.sv | 121 ++++++++++++
 tb/tb_lock_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and helpers for the canal lock controller.
// Holds FSM states, travel direction and the level width helper.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    OPEN_IN,
    WAIT_IN,
    MOVE,
    OPEN_OUT,
    WAIT_OUT
  } state_t;

  typedef enum logic {
    W2E,
    E2W
  } dir_t;

  function automatic int level_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/water_level.sv
// Pound water level: step prescaler plus saturating level counter.
// Level moves one unit after every STEP consecutive fill/drain cycles.
module water_level
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX = 10,
  parameter int STEP      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fill,
  input  logic                          drain,
  output logic [level_w(LEVEL_MAX)-1:0] level
);

  localparam int LW = level_w(LEVEL_MAX);
  localparam int CW = $clog2(STEP + 1);

  localparam logic [LW-1:0] LMAX = LW'(LEVEL_MAX);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(STEP - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= '0;
    end else if (!fill && !drain) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
      if (fill && level != LMAX)
        level <= level + 1'b1;
      else if (drain && level != '0)
        level <= level - 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Canal lock sequencer: levels the pound, admits a gondola,
// moves it to the far side and lets it out.
module lock_controller
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX = 10,
  parameter int STEP      = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arriveW,
  input  logic                          arriveE,
  input  logic                          inLock,
  output logic                          openW,
  output logic                          openE,
  output logic                          fill,
  output logic                          drain,
  output logic [level_w(LEVEL_MAX)-1:0] level,
  output logic                          busy
);

  localparam int LW = level_w(LEVEL_MAX);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] LMAX = LW'(LEVEL_MAX);

  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] entry, exit_lvl, arr_entry;

  assign entry     = (dir == W2E) ? '0 : LMAX;
  assign exit_lvl  = (dir == W2E) ? LMAX : '0;
  assign arr_entry = arriveW ? '0 : LMAX;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir   <= W2E;
    end else begin
      state <= state_n;
      dir   <= dir_n;
    end
  end

  // Counts consecutive empty WAIT_IN cycles.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_IN || inLock)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    fill    = 1'b0;
    drain   = 1'b0;
    openW   = 1'b0;
    openE   = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (arriveW || arriveE) begin
          dir_n   = arriveW ? W2E : E2W;
          state_n = (level == arr_entry) ? OPEN_IN : PREP;
        end
      end
      PREP: begin
        if (level == entry)
          state_n = OPEN_IN;
        else if (level < entry)
          fill = 1'b1;
        else
          drain = 1'b1;
      end
      OPEN_IN: begin
        openW   = (dir == W2E);
        openE   = (dir == E2W);
        state_n = WAIT_IN;
      end
      WAIT_IN: begin
        if (inLock)
          state_n = MOVE;
        else if (tcnt == TW'(TIMEOUT - 1))
          state_n = IDLE;
      end
      MOVE: begin
        if (level == exit_lvl)
          state_n = OPEN_OUT;
        else if (level < exit_lvl)
          fill = 1'b1;
        else
          drain = 1'b1;
      end
      OPEN_OUT: begin
        openE   = (dir == W2E);
        openW   = (dir == E2W);
        state_n = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (!inLock)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  water_level #(
    .LEVEL_MAX(LEVEL_MAX),
    .STEP     (STEP)
  ) u_level (
    .clk  (clk),
    .reset(reset),
    .fill (fill),
    .drain(drain),
    .level(level)
  );

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with default parameters.
// Cycle invariants are checked on every observed cycle.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       arriveW, arriveE, inLock;
  logic       openW, openE, fill, drain, busy;
  logic [3:0] level;

  int tests  = 0;
  int failed = 0;
  int n;
  int found;
  int saw;

  always #5 clk = ~clk;

  lock_controller #(
    .LEVEL_MAX(10),
    .STEP     (4),
    .TIMEOUT  (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arriveW(arriveW),
    .arriveE(arriveE),
    .inLock (inLock),
    .openW  (openW),
    .openE  (openE),
    .fill   (fill),
    .drain  (drain),
    .level  (level),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and observe 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_fill_drain", 32'(fill & drain), 0);
    check("inv_open_both", 32'(openW & openE), 0);
    check("inv_level_range", 32'(level <= 4'd10), 1);
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_openW"}, 32'(openW), 0);
    check({tag, "_openE"}, 32'(openE), 0);
    check({tag, "_fill"}, 32'(fill), 0);
    check({tag, "_drain"}, 32'(drain), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    reset   = 1'b1;
    arriveW = 1'b0;
    arriveE = 1'b0;
    inLock  = 1'b0;
    tick();
    tick();
    idle_outputs("in_reset");
    check("in_reset_level", 32'(level), 0);
    reset = 1'b0;
    tick();
    idle_outputs("post_reset");
    check("post_reset_level", 32'(level), 0);

    // W2E trip from level 0, no preparation needed
    arriveW = 1'b1;
    tick();
    arriveW = 1'b0;
    check("s1_openW", 32'(openW), 1);
    check("s1_openE", 32'(openE), 0);
    check("s1_busy", 32'(busy), 1);
    tick();
    check("s1_openW_once", 32'(openW), 0);
    inLock = 1'b1;
    tick();
    check("s1_fill_start", 32'(fill), 1);
    n = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (fill) n++;
      if (openE) begin
        found = 1;
        break;
      end
      tick();
    end
    check("s1_openE_seen", 32'(found), 1);
    check("s1_fill_cycles", 32'(n), 40);
    check("s1_level_top", 32'(level), 10);
    tick();
    check("s1_openE_once", 32'(openE), 0);
    check("s1_wait_out_busy", 32'(busy), 1);
    inLock = 1'b0;
    tick();
    check("s1_idle_busy", 32'(busy), 0);
    check("s1_idle_level", 32'(level), 10);

    // W2E request at level 10: drain first
    arriveW = 1'b1;
    tick();
    arriveW = 1'b0;
    check("s2_prep_drain", 32'(drain), 1);
    check("s2_prep_noopen", 32'(openW), 0);
    check("s2_prep_busy", 32'(busy), 1);
    n = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (drain) n++;
      if (openW) begin
        found = 1;
        break;
      end
      tick();
    end
    check("s2_openW_seen", 32'(found), 1);
    check("s2_drain_cycles", 32'(n), 40);
    check("s2_level_bottom", 32'(level), 0);
    tick();
    inLock = 1'b1;
    tick();
    n = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (fill) n++;
      if (openE) begin
        found = 1;
        break;
      end
      tick();
    end
    check("s2_openE_seen", 32'(found), 1);
    check("s2_fill_cycles", 32'(n), 40);
    tick();
    inLock = 1'b0;
    tick();
    check("s2_idle_busy", 32'(busy), 0);

    // E2W trip at level 10 opens east immediately
    arriveE = 1'b1;
    tick();
    arriveE = 1'b0;
    check("e2w_openE", 32'(openE), 1);
    check("e2w_openW", 32'(openW), 0);
    tick();
    inLock = 1'b1;
    tick();
    check("e2w_drain", 32'(drain), 1);
    n = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (drain) n++;
      if (openW) begin
        found = 1;
        break;
      end
      tick();
    end
    check("e2w_openW_seen", 32'(found), 1);
    check("e2w_drain_cycles", 32'(n), 40);
    check("e2w_level", 32'(level), 0);
    tick();
    inLock = 1'b0;
    tick();
    check("e2w_idle_busy", 32'(busy), 0);

    // Simultaneous arrival: west wins, later east arrival ignored
    arriveW = 1'b1;
    arriveE = 1'b1;
    tick();
    arriveW = 1'b0;
    check("s3_openW", 32'(openW), 1);
    check("s3_openE", 32'(openE), 0);
    check("s3_dir", 32'(dut.dir), 32'(lock_pkg::W2E));
    tick();
    check("s3_wait_openE", 32'(openE), 0);
    check("s3_wait_openW", 32'(openW), 0);
    inLock  = 1'b1;
    arriveE = 1'b0;
    tick();
    check("s3_move_fill", 32'(fill), 1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (openE) begin
        found = 1;
        break;
      end
      tick();
    end
    check("s3_openE_seen", 32'(found), 1);
    tick();
    inLock = 1'b0;
    tick();
    check("s3_idle_busy", 32'(busy), 0);

    // Return to level 0 via an E2W trip
    arriveE = 1'b1;
    tick();
    arriveE = 1'b0;
    tick();
    inLock = 1'b1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (openW) begin
        found = 1;
        break;
      end
    end
    check("ret_openW_seen", 32'(found), 1);
    tick();
    inLock = 1'b0;
    tick();
    check("ret_level", 32'(level), 0);
    check("ret_busy", 32'(busy), 0);

    // Entry timeout with gondola never entering
    arriveW = 1'b1;
    tick();
    arriveW = 1'b0;
    check("s4_openW", 32'(openW), 1);
    n = 0;
    saw = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fill) saw = 1;
      if (!busy) begin
        found = 1;
        break;
      end
      n++;
    end
    check("s4_idle_reached", 32'(found), 1);
    check("s4_wait_cycles", 32'(n), 16);
    check("s4_no_fill", 32'(saw), 0);
    check("s4_level", 32'(level), 0);

    // Reset in the middle of MOVE
    arriveW = 1'b1;
    tick();
    arriveW = 1'b0;
    tick();
    inLock = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (level == 4'd5) begin
        found = 1;
        break;
      end
    end
    check("s5_level5_reached", 32'(found), 1);
    check("s5_moving", 32'(fill), 1);
    reset = 1'b1;
    tick();
    idle_outputs("s5_in_reset");
    check("s5_in_reset_level", 32'(level), 0);
    reset  = 1'b0;
    inLock = 1'b0;
    tick();
    idle_outputs("s5_post_reset");
    check("s5_post_reset_level", 32'(level), 0);
    check("s5_state_idle", 32'(dut.state), 32'(lock_pkg::IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
